// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetchEntry_t  : one buffered instruction {pc, inst} at the default address width
//   FETCH_STATE_t : fetch control state (HALT is only reachable when the
//                   IFETCH_MISALIGN_TRAP_EN build option is defined)
//   INST_BYTES    : PC increment per fetched instruction word
package fetchPkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned INST_BYTES   = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             inst;
  } fetchEntry_t;

  typedef enum logic [0:0] {
    RUN,
    HALT
  } FETCH_STATE_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage.
// Ports:
//   clk, rstN  : clock and synchronous active-low reset
//   flush      : drop every entry, including a same-cycle push
//   push       : write pushData at the tail
//   pushData   : entry to write
//   pop        : retire the head entry (ignored when empty)
//   head       : current head entry, read straight from storage flops
//   count      : number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// Push and pop may happen together at any occupancy, including full.
module fetch_fifo
  import fetchPkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && ((cnt_q != CntW'(DEPTH)) || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem_q[wr_q] <= pushData;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words and hands them to decode.
// Ports:
//   clk, rstN                  : clock and synchronous active-low reset
//   imemReqValid/Ready/Addr    : fetch request handshake, Addr is the PC
//   imemRspValid/Data          : in-order responses, one per accepted request
//   redirect, redirectPc       : PC redirect from execute (highest priority)
//   instValid/instReady        : decode handshake
//   inst, instPc               : buffered instruction word and its PC
//   misaligned                 : only with IFETCH_MISALIGN_TRAP_EN defined;
//                                high while halted on a misaligned redirect
// Build option IFETCH_MISALIGN_TRAP_EN: a redirect to a non word-aligned
// target halts fetch until the next aligned redirect. Without it the low two
// target bits are forced to zero.
module inst_fetch
  import fetchPkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rstN,
  output logic            imemReqValid,
  input  logic            imemReqReady,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemRspValid,
  input  logic [31:0]     imemRspData,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPc,
  output logic            instValid,
  input  logic            instReady,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] instPc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CntW-1:0] out_q, out_d;    // requests accepted but not yet answered
  logic [CntW-1:0] drop_q, drop_d;  // responses still to discard after a redirect
  logic [CntW-1:0] fifo_cnt;
  logic [CntW:0]   used;
  logic            run;
  logic            fire;
  logic            rsp_drop;
  logic            fifo_push;
  logic            fifo_pop;
  logic [XLEN-1:0] target;
  entry_t          push_entry;
  entry_t          head;

  // In-flight PC queue: PC of every accepted request, retired by each response
  // whether it is kept or dropped, so it is never flushed by a redirect.
  logic [XLEN-1:0] ipc_q [DEPTH];
  logic [PtrW-1:0] ipc_wr_q;
  logic [PtrW-1:0] ipc_rd_q;

  // ---------------------------------------------------------------------------
  // Run/halt control
  // ---------------------------------------------------------------------------
`ifdef IFETCH_MISALIGN_TRAP_EN
  FETCH_STATE_t state_q, state_d;
  logic         mis_q, mis_d;
  logic         tgt_misaligned;

  assign target         = redirectPc;
  assign tgt_misaligned = (redirectPc[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    mis_d   = mis_q;
    if (redirect) begin
      if (tgt_misaligned) begin
        state_d = HALT;
        mis_d   = 1'b1;
      end else begin
        state_d = RUN;
        mis_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= RUN;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= mis_d;
    end
  end

  assign run        = (state_q == RUN);
  assign misaligned = mis_q;
`else
  assign target = redirectPc & ~XLEN'(INST_BYTES - 1);
  assign run    = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // Credits cover both in-flight requests and buffered words, so every
  // response always has a FIFO slot waiting for it.
  assign used         = {1'b0, out_q} + {1'b0, fifo_cnt};
  assign imemReqValid = rstN && run && !redirect && (used < (CntW + 1)'(DEPTH));
  assign imemReqAddr  = pc_q;
  assign fire         = imemReqValid && imemReqReady;

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  assign rsp_drop        = (drop_q != '0);
  assign fifo_push       = imemRspValid && !rsp_drop && !redirect;
  assign fifo_pop        = instValid && instReady;
  assign push_entry.pc   = ipc_q[ipc_rd_q];
  assign push_entry.inst = imemRspData;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (fire)         out_d = out_d + 1'b1;
    if (imemRspValid) out_d = out_d - 1'b1;
    if (redirect) begin
      pc_d   = target;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d = out_q - CntW'(imemRspValid);
    end else begin
      if (fire)                     pc_d   = pc_q + XLEN'(INST_BYTES);
      if (imemRspValid && rsp_drop) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      ipc_wr_q <= '0;
      ipc_rd_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      if (fire)         ipc_wr_q <= ipc_wr_q + 1'b1;
      if (imemRspValid) ipc_rd_q <= ipc_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) ipc_q[ipc_wr_q] <= pc_q;
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk      (clk),
    .rstN     (rstN),
    .flush    (redirect),
    .push     (fifo_push),
    .pushData (push_entry),
    .pop      (fifo_pop),
    .head     (head),
    .count    (fifo_cnt)
  );

  assign instValid = (fifo_cnt != '0);
  assign inst      = head.inst;
  assign instPc    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rstN;
  logic            imemReqValid;
  logic            imemReqReady;
  logic [XLEN-1:0] imemReqAddr;
  logic            imemRspValid;
  logic [31:0]     imemRspData;
  logic            redirect;
  logic [XLEN-1:0] redirectPc;
  logic            instValid;
  logic            instReady;
  logic [31:0]     inst;
  logic [XLEN-1:0] instPc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic            misaligned;
`endif

  inst_fetch #(
    .XLEN     (XLEN),
    .RESET_PC (64'h1000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .imemReqValid (imemReqValid),
    .imemReqReady (imemReqReady),
    .imemReqAddr  (imemReqAddr),
    .imemRspValid (imemRspValid),
    .imemRspData  (imemRspData),
    .redirect     (redirect),
    .redirectPc   (redirectPc),
    .instValid    (instValid),
    .instReady    (instReady),
    .inst         (inst),
    .instPc       (instPc)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .misaligned   (misaligned)
`endif
  );

  initial forever #5 clk = ~clk;

  // Memory contents: each word is its address folded with a fixed pattern.
  function automatic logic [31:0] word(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  // ---------------------------------------------------------------------------
  // Memory model: accepts only granted requests, answers after lat cycles.
  // ---------------------------------------------------------------------------
  int unsigned     granted = 0;
  int unsigned     taken   = 0;
  int unsigned     lat     = 1;
  logic            sr_v [4];
  logic [XLEN-1:0] sr_a [4];
  logic            fire;

  assign imemReqReady = (granted != taken);
  assign fire         = imemReqValid && imemReqReady;
  assign imemRspValid = sr_v[lat-1];
  assign imemRspData  = word(sr_a[lat-1]);

  always @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 4; i++) sr_v[i] <= 1'b0;
    end else begin
      sr_v[0] <= fire;
      sr_a[0] <= imemReqAddr;
      for (int i = 1; i < 4; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_a[i] <= sr_a[i-1];
      end
    end
    if (fire) taken <= taken + 1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] exp_req [$];
  logic [XLEN-1:0] exp_ipc [$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              n_fire   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Grant n requests starting at start; keep=0 means their data must be dropped.
  task automatic grant(input int n, input logic [XLEN-1:0] start, input bit keep);
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(start + XLEN'(4 * i));
      if (keep) exp_ipc.push_back(start + XLEN'(4 * i));
    end
    granted += n;
  endtask

  always begin : req_monitor
    @(negedge clk);
    #4;
    if (rstN && fire) begin
      n_fire++;
      if (exp_req.size() == 0) begin
        n_checks++;
        $display("FAIL req_extra: got request %h, expected none", imemReqAddr);
      end else begin
        check("req_addr", imemReqAddr, exp_req.pop_front());
      end
    end
  end

  always begin : inst_monitor
    logic [XLEN-1:0] epc;
    @(negedge clk);
    #4;
    if (rstN && instValid && instReady) begin
      if (exp_ipc.size() == 0) begin
        n_checks++;
        $display("FAIL inst_extra: got instPc %h, expected no instruction", instPc);
      end else begin
        epc = exp_ipc.pop_front();
        check("inst_pc", instPc, epc);
        check("inst_data", {32'h0, inst}, {32'h0, word(epc)});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((exp_req.size() != 0 || exp_ipc.size() != 0) && k < max) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", exp_req.size() + exp_ipc.size(), 0);
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    int n0;
    rstN       = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    instReady  = 1'b1;

    // Reset state
    idle(3);
    #4;
    check("rst_reqvalid", imemReqValid, 0);
    check("rst_instvalid", instValid, 0);
    check("rst_inst", inst, 0);
    check("rst_instpc", instPc, 0);

    // Reset release: back-to-back requests and deliveries
    @(negedge clk);
    rstN = 1'b1;
    grant(3, 64'h1000, 1'b1);
    #4 check("p1_req_c1", fire, 1);
    @(negedge clk); #4 check("p1_req_c2", fire, 1);
    @(negedge clk); #4 check("p1_req_c3", fire, 1);
    check("p1_inst_c3", instValid, 1);
    @(negedge clk); #4 check("p1_inst_c4", instValid, 1);
    @(negedge clk); #4 check("p1_inst_c5", instValid, 1);
    @(negedge clk); #4 check("p1_inst_c6", instValid, 0);

    // Decode stalled for 10 cycles: only DEPTH words may be in flight or buffered
    @(negedge clk);
    instReady = 1'b0;
    grant(6, 64'h100C, 1'b1);
    n0 = n_fire;
    idle(9);
    @(negedge clk);
    check("p2_stall_fires", n_fire - n0, DEPTH);
    check("p2_full_valid", instValid, 1);
    instReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #4 check("p2_back_to_back", instValid, 1);
      @(negedge clk);
    end
    drain(20);

    // Redirect with two requests outstanding
    idle(4);
    lat = 3;
    grant(2, 64'h1024, 1'b0);
    idle(2);
    redirect   = 1'b1;
    redirectPc = 64'h2000;
    #4 check("p3_no_req_on_redirect", imemReqValid, 0);
    @(negedge clk);
    redirect = 1'b0;
    grant(2, 64'h2000, 1'b1);
    #4 check("p3_req_after_redirect", fire, 1);
    @(negedge clk); #4 check("p3_no_old_inst", instValid, 0);
    drain(30);

    // Redirect together with a response and a pop
    idle(4);
    lat = 1;
    grant(1, 64'h2008, 1'b1);
    grant(1, 64'h200C, 1'b0);
    idle(2);
    redirect   = 1'b1;
    redirectPc = 64'h3000;
    #4 check("p4_pop_in_redirect", instValid, 1);
    check("p4_rsp_in_redirect", imemRspValid, 1);
    @(negedge clk);
    redirect = 1'b0;
    grant(1, 64'h3000, 1'b1);
    #4 check("p4_req_target", fire, 1);
    check("p4_flushed", instValid, 0);
    drain(20);

    // PC wrap at the top of the address space
    idle(2);
    redirect   = 1'b1;
    redirectPc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    grant(2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    drain(20);

    // Misaligned redirect target
    idle(2);
    redirect   = 1'b1;
    redirectPc = 64'h2002;
    @(negedge clk);
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    #4 check("p6_misaligned_set", misaligned, 1);
    check("p6_halt_no_req", imemReqValid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4 check("p6_halt_hold", imemReqValid, 0);
    end
    @(negedge clk);
    redirect   = 1'b1;
    redirectPc = 64'h3000;
    @(negedge clk);
    redirect = 1'b0;
    grant(1, 64'h3000, 1'b1);
    #4 check("p6_misaligned_clr", misaligned, 0);
    check("p6_resume", fire, 1);
`else
    grant(1, 64'h2000, 1'b1);
    #4 check("p6_aligned_req", fire, 1);
`endif
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
